// File: rtl/bitmap_encoder_pkg.sv
// Shared CPU width constants and helpers for the bitmap encoder and its decoder counterpart.
// The encoder's default widths sit next to the matching decoder widths.
package bitmap_encoder_pkg;

    localparam int DEC_IN_W  = 6;
    localparam int DEC_OUT_W = 64;

    localparam int ENC_WIDTH = DEC_OUT_W;
    localparam int ENC_IDX_W = DEC_IN_W;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } enc_state_t;

    // Narrower vectors are zero-extended by the caller.
    function automatic logic at_most_one_hot(input logic [63:0] v);
        return (v & (v - 64'd1)) == 64'd0;
    endfunction

endpackage

// File: rtl/bitmap_encoder_prio_enc_lsb.sv
// Combinational lowest-set-bit priority encoder; out is 0 when no bit is set.
module prio_enc_lsb #(
    parameter int WIDTH = 64,
    parameter int IDX_W = 6
) (
    input  logic [WIDTH-1:0] in,
    output logic [IDX_W-1:0] out
);

    logic [IDX_W-1:0] idx_const [WIDTH];

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_idx
            assign idx_const[gi] = IDX_W'(gi);
        end
    endgenerate

    // Scan from the top down so the lowest set bit wins.
    always_comb begin
        out = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (in[i]) begin
                out = idx_const[i];
            end
        end
    end

endmodule

// File: rtl/bitmap_encoder.sv
// Serializes a multi-hot bitmap into one index beat per set bit, lowest first.
// An all-zero bitmap yields a single beat flagged with none.
module bitmap_encoder
    import bitmap_encoder_pkg::*;
#(
    parameter int WIDTH = ENC_WIDTH,
    parameter int IDX_W = ENC_IDX_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             validin,
    input  logic [WIDTH-1:0] bitmap,
    output logic             allowin,
    output logic             validout,
    input  logic             allowout,
    input  logic             cancel,
    output logic [IDX_W-1:0] idx,
    output logic             last,
    output logic             none
);

    enc_state_t       state_reg, state_next;
    logic [WIDTH-1:0] pending_reg, pending_next;
    logic             none_reg, none_next;

    logic busy;
    logic accept;

    prio_enc_lsb #(
        .WIDTH(WIDTH),
        .IDX_W(IDX_W)
    ) u_prio (
        .in (pending_reg),
        .out(idx)
    );

    assign busy     = (state_reg == BUSY);
    assign last     = busy & at_most_one_hot(64'(pending_reg));
    assign none     = busy & none_reg;
    assign validout = busy & ~cancel;
    assign allowin  = ~busy | (busy & last & allowout & ~cancel);
    assign accept   = validin & allowin;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= IDLE;
            pending_reg <= '0;
            none_reg    <= 1'b0;
        end else begin
            state_reg   <= state_next;
            pending_reg <= pending_next;
            none_reg    <= none_next;
        end
    end

    // Cancel outranks everything in BUSY; allowin is already low then, so no accept can collide.
    always_comb begin
        state_next   = state_reg;
        pending_next = pending_reg;
        none_next    = none_reg;
        if (busy && cancel) begin
            state_next   = IDLE;
            pending_next = '0;
            none_next    = 1'b0;
        end else if (accept) begin
            state_next   = BUSY;
            pending_next = bitmap;
            none_next    = (bitmap == '0);
        end else if (validout && allowout) begin
            if (last) begin
                state_next   = IDLE;
                pending_next = '0;
                none_next    = 1'b0;
            end else begin
                pending_next = pending_reg & (pending_reg - WIDTH'(1));
            end
        end
    end

endmodule

// File: tb/tb_bitmap_encoder.sv
// Directed bench for bitmap_encoder: load, stall, cancel, back-to-back and async reset cases.
module tb_bitmap_encoder;

    logic        clk;
    logic        rst;
    logic        validin;
    logic [63:0] bitmap;
    logic        allowin;
    logic        validout;
    logic        allowout;
    logic        cancel;
    logic [5:0]  idx;
    logic        last;
    logic        none;

    int total = 0;
    int fails = 0;

    bitmap_encoder #(
        .WIDTH(64),
        .IDX_W(6)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .validin (validin),
        .bitmap  (bitmap),
        .allowin (allowin),
        .validout(validout),
        .allowout(allowout),
        .cancel  (cancel),
        .idx     (idx),
        .last    (last),
        .none    (none)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Beat check: validout, idx, last, none together.
    task automatic beat(input string tag, input logic v, input logic [5:0] i, input logic l, input logic n);
        check({tag, ".validout"}, 64'(validout), 64'(v));
        check({tag, ".idx"},      64'(idx),      64'(i));
        check({tag, ".last"},     64'(last),     64'(l));
        check({tag, ".none"},     64'(none),     64'(n));
        $display("beat %-12s validout=%0d idx=%0d last=%0d none=%0d allowin=%0d",
                 tag, validout, idx, last, none, allowin);
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst      = 1'b1;
        validin  = 1'b0;
        bitmap   = '0;
        allowout = 1'b0;
        cancel   = 1'b0;
        #12;
        beat("reset", 1'b0, 6'd0, 1'b0, 1'b0);
        check("reset.allowin", 64'(allowin), 64'd1);
        rst = 1'b0;
        tick();

        // Three set bits, the top one last.
        validin  = 1'b1;
        bitmap   = 64'h8000_0000_0000_0011;
        allowout = 1'b1;
        #1;
        check("l1.allowin", 64'(allowin), 64'd1);
        tick();
        validin = 1'b0;
        #1;
        beat("l1.b0", 1'b1, 6'd0, 1'b0, 1'b0);
        check("l1.b0.allowin", 64'(allowin), 64'd0);
        tick(); #1;
        beat("l1.b1", 1'b1, 6'd4, 1'b0, 1'b0);
        tick(); #1;
        beat("l1.b2", 1'b1, 6'd63, 1'b1, 1'b0);
        check("l1.b2.allowin", 64'(allowin), 64'd1);
        tick(); #1;
        beat("l1.done", 1'b0, 6'd0, 1'b0, 1'b0);

        // All-zero bitmap: a single none beat.
        validin = 1'b1;
        bitmap  = 64'h0;
        tick();
        validin = 1'b0;
        #1;
        beat("zero.b0", 1'b1, 6'd0, 1'b1, 1'b1);
        tick(); #1;
        beat("zero.done", 1'b0, 6'd0, 1'b0, 1'b0);
        check("zero.allowin", 64'(allowin), 64'd1);

        // Stall three cycles, then drain.
        validin  = 1'b1;
        bitmap   = 64'h6;
        allowout = 1'b0;
        tick();
        validin = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #1;
            beat("stall.hold", 1'b1, 6'd1, 1'b0, 1'b0);
            tick();
        end
        allowout = 1'b1;
        #1;
        beat("stall.b0", 1'b1, 6'd1, 1'b0, 1'b0);
        tick(); #1;
        beat("stall.b1", 1'b1, 6'd2, 1'b1, 1'b0);
        tick(); #1;
        beat("stall.done", 1'b0, 6'd0, 1'b0, 1'b0);

        // Cancel on the second beat while a new bitmap is offered.
        validin = 1'b1;
        bitmap  = 64'hF0;
        tick();
        validin = 1'b0;
        #1;
        beat("can.b0", 1'b1, 6'd4, 1'b0, 1'b0);
        tick();
        cancel  = 1'b1;
        validin = 1'b1;
        bitmap  = 64'hFF;
        #1;
        check("can.validout", 64'(validout), 64'd0);
        check("can.allowin", 64'(allowin), 64'd0);
        tick();
        cancel  = 1'b0;
        validin = 1'b0;
        #1;
        beat("can.done", 1'b0, 6'd0, 1'b0, 1'b0);

        // Back-to-back load on the final beat.
        validin = 1'b1;
        bitmap  = 64'h1;
        tick();
        bitmap = 64'h300;
        #1;
        beat("b2b.b0", 1'b1, 6'd0, 1'b1, 1'b0);
        check("b2b.allowin", 64'(allowin), 64'd1);
        tick();
        validin = 1'b0;
        #1;
        beat("b2b.b1", 1'b1, 6'd8, 1'b0, 1'b0);
        tick(); #1;
        beat("b2b.b2", 1'b1, 6'd9, 1'b1, 1'b0);
        tick(); #1;
        beat("b2b.done", 1'b0, 6'd0, 1'b0, 1'b0);

        // Cancel while idle must not block an accept.
        cancel  = 1'b1;
        validin = 1'b1;
        bitmap  = 64'h5;
        #1;
        check("icancel.allowin", 64'(allowin), 64'd1);
        tick();
        cancel  = 1'b0;
        validin = 1'b0;
        #1;
        beat("icancel.b0", 1'b1, 6'd0, 1'b0, 1'b0);
        tick(); #1;
        beat("icancel.b1", 1'b1, 6'd2, 1'b1, 1'b0);
        tick(); #1;

        // Asynchronous reset mid-bitmap.
        validin = 1'b1;
        bitmap  = 64'hFF;
        tick();
        validin = 1'b0;
        #1;
        beat("rst.b0", 1'b1, 6'd0, 1'b0, 1'b0);
        tick(); #1;
        beat("rst.b1", 1'b1, 6'd1, 1'b0, 1'b0);
        rst = 1'b1;
        #1;
        check("rst.async.validout", 64'(validout), 64'd0);
        check("rst.async.allowin", 64'(allowin), 64'd1);
        tick();
        #2;
        rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick(); #1;
            beat("rst.after", 1'b0, 6'd0, 1'b0, 1'b0);
        end
        check("rst.allowin", 64'(allowin), 64'd1);

        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end

endmodule
